// File: rtl/regfile_decoded_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : regfile_decoded_pkg                                     |
// | Desc   : Shared defaults and types for the decoded register file |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package regfile_decoded_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = 5;

  // Index of the hardwired-zero register
  localparam int ZERO_REG = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_decoded_pkg
`default_nettype wire

// File: rtl/regfile_decoded_decoder_onehot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : decoder_onehot                                          |
// | Desc   : Parametrised binary-to-one-hot decoder with enable.     |
// |          Only OUT_N outputs exist, so codes >= OUT_N select      |
// |          nothing.                                                |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module decoder_onehot #(
  parameter int IN_W  = 5,
  parameter int OUT_N = 32
) (
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_N-1:0] out
);

  generate
    for (genvar k = 0; k < OUT_N; k++) begin : g_bit
      // Each output fires only for its own code while enabled
      assign out[k] = en & (in == IN_W'(k));
    end
  endgenerate

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/regfile_decoded.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : regfile_decoded                                         |
// | Desc   : NUM_REGS x WIDTH register file, one write port, two     |
// |          combinational read ports, register 0 reads as zero.     |
// |          Optional macro REGFILE_BYPASS_EN forwards same-cycle    |
// |          write data to a matching read port.                     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module regfile_decoded
  import regfile_decoded_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeRegister,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB
);

  // First register that has real storage; register 0 is a constant
  localparam int c_FIRST_REG = ZERO_REG + 1;

  logic [NUM_REGS-1:0] w_we_onehot;
  logic                w_unused_we0;
  logic [WIDTH-1:0]    regs_q [c_FIRST_REG:NUM_REGS-1];
  logic [WIDTH-1:0]    regs_d [c_FIRST_REG:NUM_REGS-1];

  decoder_onehot #(
    .IN_W  (ADDR_W),
    .OUT_N (NUM_REGS)
  ) u_wr_dec (
    .in  (ctrl_writeRegister),
    .en  (ctrl_writeEnable),
    .out (w_we_onehot)
  );

  // Register 0 has no storage, so its decoded enable goes nowhere
  assign w_unused_we0 = w_we_onehot[ZERO_REG];

  // Next state: load write data into whichever register is selected
  always_comb begin
    regs_d = regs_q;
    for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
      if (w_we_onehot[k]) begin
        regs_d[k] = data_writeReg;
      end
    end
  end

  // Storage; reset clears immediately and wins over a coincident write
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port A: address 0 and unmatched (out-of-range) codes give zero
  always_comb begin
    data_readRegA = '0;
    for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
      if (ctrl_readRegA == ADDR_W'(k)) begin
        data_readRegA = regs_q[k];
      end
    end
`ifdef REGFILE_BYPASS_EN
    for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
      if (!ctrl_reset && w_we_onehot[k] && (ctrl_readRegA == ADDR_W'(k))) begin
        data_readRegA = data_writeReg;
      end
    end
`endif
  end

  // Read port B: same structure as port A, fully independent
  always_comb begin
    data_readRegB = '0;
    for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
      if (ctrl_readRegB == ADDR_W'(k)) begin
        data_readRegB = regs_q[k];
      end
    end
`ifdef REGFILE_BYPASS_EN
    for (int k = c_FIRST_REG; k < NUM_REGS; k++) begin
      if (!ctrl_reset && w_we_onehot[k] && (ctrl_readRegB == ADDR_W'(k))) begin
        data_readRegB = data_writeReg;
      end
    end
`endif
  end

endmodule : regfile_decoded
`default_nettype wire

// File: tb/tb_regfile_decoded.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_regfile_decoded                                      |
// | Desc   : Self-checking bench for regfile_decoded, default build  |
// |          and a 24 x 16 variant, against an array model. Honours  |
// |          REGFILE_BYPASS_EN when defined.                         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_regfile_decoded;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;

  logic        we32 = 1'b0;
  logic [4:0]  wa32 = '0, ra32 = '0, rb32 = '0;
  logic [31:0] wd32 = '0;
  logic [31:0] rda32, rdb32;

  logic        we16 = 1'b0;
  logic [4:0]  wa16 = '0, ra16 = '0, rb16 = '0;
  logic [15:0] wd16 = '0;
  logic [15:0] rda16, rdb16;

  int errors = 0;
  int checks = 0;

  logic [31:0] m32 [32];
  logic [31:0] m16 [32];

  regfile_decoded dut32 (
    .clock              (clock),
    .ctrl_reset         (ctrl_reset),
    .ctrl_writeEnable   (we32),
    .ctrl_writeRegister (wa32),
    .data_writeReg      (wd32),
    .ctrl_readRegA      (ra32),
    .ctrl_readRegB      (rb32),
    .data_readRegA      (rda32),
    .data_readRegB      (rdb32)
  );

  regfile_decoded #(.WIDTH(16), .NUM_REGS(24), .ADDR_W(5)) dut16 (
    .clock              (clock),
    .ctrl_reset         (ctrl_reset),
    .ctrl_writeEnable   (we16),
    .ctrl_writeRegister (wa16),
    .data_writeReg      (wd16),
    .ctrl_readRegA      (ra16),
    .ctrl_readRegB      (rb16),
    .data_readRegA      (rda16),
    .data_readRegB      (rdb16)
  );

  always #5 clock = ~clock;

  // An unknown write strobe must never reach the register file
  always @(posedge clock) begin
    if (!ctrl_reset) begin
      assert (!$isunknown(we32) && !$isunknown(we16)) else begin
        errors++;
        $error("FAIL we_known observed=%b/%b expected=known", we32, we16);
      end
    end
  end

  // Architectural view of a read: zero for r0, out-of-range or reset
  function automatic logic [31:0] exp_rd(int n, logic [31:0] m [32], logic [4:0] ra,
                                         logic we, logic [4:0] wa, logic [31:0] wd,
                                         logic rst);
    if (rst) return 32'h0;
    if (ra == 5'd0 || int'(ra) >= n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m[ra];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(string tag);
    chk({tag, "_a32"}, rda32, exp_rd(32, m32, ra32, we32, wa32, wd32, ctrl_reset));
    chk({tag, "_b32"}, rdb32, exp_rd(32, m32, rb32, we32, wa32, wd32, ctrl_reset));
    chk({tag, "_a16"}, {16'h0, rda16}, exp_rd(24, m16, ra16, we16, wa16, {16'h0, wd16}, ctrl_reset));
    chk({tag, "_b16"}, {16'h0, rdb16}, exp_rd(24, m16, rb16, we16, wa16, {16'h0, wd16}, ctrl_reset));
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      m32[i] = 32'h0;
      m16[i] = 32'h0;
    end
  endtask

  // Check reads before the edge, clock once, then apply the write rules
  task automatic cycle(string tag);
    #1;
    check_reads(tag);
    @(posedge clock);
    #1;
    if (ctrl_reset) begin
      clear_models();
    end else begin
      if (we32 && wa32 != 5'd0) m32[wa32] = wd32;
      if (we16 && wa16 != 5'd0 && int'(wa16) < 24) m16[wa16] = {16'h0, wd16};
    end
    we32 = 1'b0;
    we16 = 1'b0;
  endtask

  initial begin
    clear_models();

    // Reset held from time zero
    ra32 = 5'd1; rb32 = 5'd2; ra16 = 5'd1; rb16 = 5'd2;
    #2;
    check_reads("reset_init");
    repeat (2) @(posedge clock);
    #2;
    ctrl_reset = 1'b0;

    // Async reset between edges after writing r5
    we32 = 1'b1; wa32 = 5'd5; wd32 = 32'hDEADBEEF;
    cycle("wr_r5");
    ra32 = 5'd5; rb32 = 5'd5;
    #1;
    chk("r5_before_rst", rda32, 32'hDEADBEEF);
    #2;
    ctrl_reset = 1'b1;
    #1;
    clear_models();
    chk("rst_async_a", rda32, 32'h0);
    chk("rst_async_b", rdb32, 32'h0);
    // Write across an edge with reset still high must be dropped
    we32 = 1'b1; wa32 = 5'd6; wd32 = 32'h0BAD0BAD;
    cycle("wr_in_rst");
    #2;
    ctrl_reset = 1'b0;
    ra32 = 5'd5; rb32 = 5'd6;
    cycle("post_rst");

    // Basic write then read, latency of one edge
    we32 = 1'b1; wa32 = 5'd7; wd32 = 32'h12345678; ra32 = 5'd7; rb32 = 5'd7;
    cycle("wr_r7");
    cycle("rd_r7");

    // Writes to r0 are discarded, other registers untouched
    we32 = 1'b1; wa32 = 5'd0; wd32 = 32'hFFFFFFFF; ra32 = 5'd0; rb32 = 5'd7;
    cycle("wr_r0");
    cycle("rd_r0");

    // Full sweep: unique pattern per register, then crossed read pairs
    for (int i = 1; i < 32; i++) begin
      we32 = 1'b1; wa32 = 5'(i); wd32 = 32'(i) * 32'h01010101;
      we16 = 1'b1; wa16 = 5'(i); wd16 = 16'(i) * 16'h0101;
      cycle("sweep_wr");
    end
    for (int i = 0; i < 32; i++) begin
      ra32 = 5'(i); rb32 = 5'(31 - i); ra16 = 5'(i); rb16 = 5'(31 - i);
      #1;
      chk("sweep_a32", rda32, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
      check_reads("sweep_rd");
    end

    // Same-address read and write
    we32 = 1'b1; wa32 = 5'd3; wd32 = 32'hA;
    cycle("wr_r3_a");
    we32 = 1'b1; wa32 = 5'd3; wd32 = 32'hB; ra32 = 5'd3; rb32 = 5'd4;
    cycle("raw_r3_pre");
    chk("raw_r3_post", rda32, 32'hB);

    // Variant: out-of-range write changes nothing, r23 works
    we16 = 1'b1; wa16 = 5'd23; wd16 = 16'h1234;
    cycle("v_wr_r23");
    we16 = 1'b1; wa16 = 5'd28; wd16 = 16'hBEEF; ra16 = 5'd28; rb16 = 5'd28;
    cycle("v_wr_oor");
    chk("v_rd_28", {16'h0, rda16}, 32'h0);
    chk("v_rd_23_const", {16'h0, rdb16}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra16 = 5'(i); rb16 = 5'd23;
      #1;
      check_reads("v_scan");
    end
    chk("v_r23", {16'h0, rdb16}, 32'h1234);

    // Randomised traffic on both instances
    for (int n = 0; n < 300; n++) begin
      we32 = 1'($urandom); wa32 = 5'($urandom); wd32 = $urandom;
      we16 = 1'($urandom); wa16 = 5'($urandom); wd16 = 16'($urandom);
      ra32 = ($urandom_range(3) == 0) ? wa32 : 5'($urandom);
      rb32 = 5'($urandom);
      ra16 = ($urandom_range(3) == 0) ? wa16 : 5'($urandom);
      rb16 = 5'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_decoded
`default_nettype wire
